// File: rtl/if_neuron_sched.sv
// if_neuron_sched: time-multiplexes one IF neuron over NUM_NEURONS per timestep; IF_SCHED_SPIKE_CNT_EN adds spike_cnt.
// Latency NUM_NEURONS*(NUM_INPUTS+5)+1 cycles start->done; no backpressure, start is ignored (not queued) while busy.
module if_neuron_sched #(
  parameter int NUM_NEURONS = 20,
  parameter int NUM_INPUTS  = 20,
  parameter int NIDX_W      = 5,
  parameter int IIDX_W      = 5,
  parameter int WADDR_W     = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  output logic                   busy,
  output logic                   done,
  output logic                   vmem_rd_en,
  output logic [NIDX_W-1:0]      vmem_rd_addr,
  input  logic [15:0]            vmem_rd_data,
  output logic                   vmem_wr_en,
  output logic [NIDX_W-1:0]      vmem_wr_addr,
  output logic [15:0]            vmem_wr_data,
  output logic [IIDX_W-1:0]      act_addr,
  output logic [WADDR_W-1:0]     w_addr,
  output logic                   nrn_load_en,
  output logic                   nrn_input_valid,
  output logic                   nrn_output_en,
  output logic                   nrn_arithm,
  output logic [15:0]            nrn_mem_vol,
  input  logic [15:0]            nrn_out_mem_vol,
  input  logic                   nrn_spike,
  output logic [NUM_NEURONS-1:0] spike_vec
`ifdef IF_SCHED_SPIKE_CNT_EN
  ,
  output logic [NIDX_W:0]        spike_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FIRE  = 3'd5;
  localparam logic [2:0] S_WB    = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [NIDX_W-1:0]  N_LAST = NIDX_W'(NUM_NEURONS - 1);
  localparam logic [IIDX_W-1:0]  J_LAST = IIDX_W'(NUM_INPUTS - 1);
  localparam logic [WADDR_W-1:0] W_STEP = WADDR_W'(NUM_INPUTS);

  logic [2:0]             state_q, state_d;
  logic [NIDX_W-1:0]      n_q, n_d;
  logic [IIDX_W-1:0]      j_q, j_d;
  logic [WADDR_W-1:0]     w_base_q, w_base_d;
  logic                   mode_q, mode_d;
  logic                   valid_q, valid_d;
  logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
`ifdef IF_SCHED_SPIKE_CNT_EN
  localparam int CNT_W = NIDX_W + 1;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    j_d         = j_q;
    w_base_d    = w_base_q;
    mode_d      = mode_q;
    spike_vec_d = spike_vec_q;
`ifdef IF_SCHED_SPIKE_CNT_EN
    cnt_d       = cnt_q;
`endif
    // Data for the address issued in ACC arrives one cycle later, so valid trails by one.
    valid_d     = (state_q == S_ACC);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          spike_vec_d = '0;
          n_d         = '0;
          w_base_d    = '0;
`ifdef IF_SCHED_SPIKE_CNT_EN
          cnt_d       = '0;
`endif
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        j_d     = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (j_q == J_LAST) begin
          state_d = S_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_FIRE;
      S_FIRE:  state_d = S_WB;
      S_WB: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (n_q == NIDX_W'(i)) begin
            spike_vec_d[i] = nrn_spike;
          end
        end
`ifdef IF_SCHED_SPIKE_CNT_EN
        cnt_d = cnt_q + CNT_W'(nrn_spike);
`endif
        if (n_q == N_LAST) begin
          state_d = S_DONE;
        end else begin
          n_d      = n_q + 1'b1;
          w_base_d = w_base_q + W_STEP;
          state_d  = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      j_q         <= '0;
      w_base_q    <= '0;
      mode_q      <= 1'b0;
      valid_q     <= 1'b0;
      spike_vec_q <= '0;
`ifdef IF_SCHED_SPIKE_CNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      j_q         <= j_d;
      w_base_q    <= w_base_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      spike_vec_q <= spike_vec_d;
`ifdef IF_SCHED_SPIKE_CNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign vmem_rd_en      = (state_q == S_FETCH);
  assign vmem_rd_addr    = n_q;
  assign vmem_wr_en      = (state_q == S_WB);
  assign vmem_wr_addr    = n_q;
  assign vmem_wr_data    = nrn_out_mem_vol;
  assign act_addr        = j_q;
  assign w_addr          = w_base_q + WADDR_W'(j_q);
  assign nrn_load_en     = (state_q == S_LOAD);
  assign nrn_input_valid = valid_q;
  assign nrn_output_en   = (state_q == S_FIRE);
  assign nrn_arithm      = mode_q;
  assign nrn_mem_vol     = vmem_rd_data;
  assign spike_vec       = spike_vec_q;
`ifdef IF_SCHED_SPIKE_CNT_EN
  assign spike_cnt       = cnt_q;
`endif

endmodule

// File: tb/tb_if_neuron_sched.sv
// Bench for if_neuron_sched: VMEM/ROM/neuron environment models plus a write-back scoreboard.
module tb_if_neuron_sched;
  localparam int NN = 3;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, mode, do_load;
  logic        busy, done, vmem_rd_en, vmem_wr_en;
  logic [1:0]  vmem_rd_addr, vmem_wr_addr, act_addr;
  logic [3:0]  w_addr;
  logic [15:0] vmem_rd_data, vmem_wr_data, nrn_mem_vol, nrn_out_mem_vol;
  logic        nrn_load_en, nrn_input_valid, nrn_output_en, nrn_arithm, nrn_spike;
  logic [NN-1:0] spike_vec;
`ifdef IF_SCHED_SPIKE_CNT_EN
  logic [2:0]  spike_cnt;
  logic [1:0]  spike_cnt1;
`endif

  // Second instance: single neuron, single input.
  logic        start1, busy1, done1, rd_en1, wr_en1;
  logic [0:0]  rd_addr1, wr_addr1, act_addr1, w_addr1, spike_vec1;
  logic [15:0] wr_data1, mem_vol1;
  logic        load1, valid1, oen1, arith1;
  logic [15:0] rd_data1 = 16'd5;
  logic [15:0] out_v1 = 16'd0;
  logic        spk1 = 1'b0;

  if_neuron_sched #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .NIDX_W(2), .IIDX_W(2), .WADDR_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .vmem_rd_en(vmem_rd_en), .vmem_rd_addr(vmem_rd_addr), .vmem_rd_data(vmem_rd_data),
    .vmem_wr_en(vmem_wr_en), .vmem_wr_addr(vmem_wr_addr), .vmem_wr_data(vmem_wr_data),
    .act_addr(act_addr), .w_addr(w_addr), .nrn_load_en(nrn_load_en),
    .nrn_input_valid(nrn_input_valid), .nrn_output_en(nrn_output_en), .nrn_arithm(nrn_arithm),
    .nrn_mem_vol(nrn_mem_vol), .nrn_out_mem_vol(nrn_out_mem_vol), .nrn_spike(nrn_spike),
    .spike_vec(spike_vec)
`ifdef IF_SCHED_SPIKE_CNT_EN
    , .spike_cnt(spike_cnt)
`endif
  );

  if_neuron_sched #(.NUM_NEURONS(1), .NUM_INPUTS(1), .NIDX_W(1), .IIDX_W(1), .WADDR_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(1'b0), .busy(busy1), .done(done1),
    .vmem_rd_en(rd_en1), .vmem_rd_addr(rd_addr1), .vmem_rd_data(rd_data1),
    .vmem_wr_en(wr_en1), .vmem_wr_addr(wr_addr1), .vmem_wr_data(wr_data1),
    .act_addr(act_addr1), .w_addr(w_addr1), .nrn_load_en(load1),
    .nrn_input_valid(valid1), .nrn_output_en(oen1), .nrn_arithm(arith1),
    .nrn_mem_vol(mem_vol1), .nrn_out_mem_vol(out_v1), .nrn_spike(spk1),
    .spike_vec(spike_vec1)
`ifdef IF_SCHED_SPIKE_CNT_EN
    , .spike_cnt(spike_cnt1)
`endif
  );

  // Environment: VMEM, activation/weight ROMs (1-cycle read), behavioural neuron.
  logic [15:0] vmem [4];
  logic [15:0] vmem_init [4];
  logic [15:0] act_mem [4];
  logic [15:0] w_mem [16];
  logic [15:0] act_dat, w_dat, nv, out_v;
  logic        spk;
  logic [1:0]  act_cap;
  logic [3:0]  w_cap;

  assign nrn_out_mem_vol = out_v;
  assign nrn_spike       = spk;

  // Neuron model: spikes at v>=100; voltages of 128 and above fold down by 127.
  function automatic logic [15:0] wrap_v(input logic [15:0] v);
    return (v >= 16'd128) ? v - 16'd127 : v;
  endfunction

  always @(posedge clk) begin
    act_dat <= act_mem[act_addr];
    w_dat   <= w_mem[w_addr];
    act_cap <= act_addr;
    w_cap   <= w_addr;
    if (vmem_rd_en) vmem_rd_data <= vmem[vmem_rd_addr];
    if (do_load) vmem <= vmem_init;
    else if (vmem_wr_en) vmem[vmem_wr_addr] <= vmem_wr_data;
    if (nrn_load_en) nv <= nrn_mem_vol;
    else if (nrn_input_valid) nv <= nv + (nrn_arithm ? act_dat : 16'(act_dat * w_dat));
    if (nrn_output_en) begin
      out_v <= wrap_v(nv);
      spk   <= (nv >= 16'd100);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int          rd_q[$];
  int          wr_a_q[$];
  logic [15:0] wr_d_q[$];
  logic [15:0] exp_vmem [NN];
  int          wr_cnt = 0;
  int          cur_n = 0;
  int          vk = 0;
  logic        prev_valid = 1'b0;

  // Monitor: read order, write-back scoreboard, strobe exclusivity, address/valid alignment.
  always @(negedge clk) begin
    int s;
    s = int'(nrn_load_en) + int'(nrn_input_valid) + int'(nrn_output_en) + int'(vmem_rd_en) + int'(vmem_wr_en);
    if (s != 0) check_eq("strobe_excl", s, 1);
    if (vmem_rd_en) begin
      if (rd_q.size() == 0) check_eq("rd_unexpected", 1, 0);
      else check_eq("rd_addr", vmem_rd_addr, rd_q.pop_front());
      cur_n = int'(vmem_rd_addr);
    end
    if (vmem_wr_en) begin
      wr_cnt++;
      if (wr_a_q.size() == 0) check_eq("wr_unexpected", 1, 0);
      else begin
        check_eq("wr_addr", vmem_wr_addr, wr_a_q.pop_front());
        check_eq("wr_data", vmem_wr_data, wr_d_q.pop_front());
      end
    end
    if (nrn_load_en) vk = 0;
    if (nrn_input_valid) begin
      check_eq("act_addr", act_cap, vk);
      check_eq("w_addr", w_cap, cur_n * NI + vk);
      vk++;
    end
    if (nrn_output_en) begin
      check_eq("valid_count", vk, NI);
      check_eq("valid_in_drain", prev_valid, 1);
    end
    prev_valid = nrn_input_valid;
  end

  task automatic load_mem(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
    vmem_init[0] = v0; vmem_init[1] = v1; vmem_init[2] = v2; vmem_init[3] = 16'd0;
    exp_vmem[0] = v0;  exp_vmem[1] = v1;  exp_vmem[2] = v2;
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic run_ts(input logic m, input bit poke, input int abort_at);
    logic [NN-1:0] es;
    logic [15:0]   v;
    logic [15:0]   saved [NN];
    int c, done_cyc, ndone, arith_bad, wr0, pop;
    pop = 0;
    for (int n = 0; n < NN; n++) begin
      saved[n] = exp_vmem[n];
      v = exp_vmem[n];
      for (int j = 0; j < NI; j++)
        v = v + (m ? act_mem[j] : 16'(act_mem[j] * w_mem[n * NI + j]));
      es[n] = (v >= 16'd100);
      pop += int'(es[n]);
      v = wrap_v(v);
      exp_vmem[n] = v;
      rd_q.push_back(n);
      wr_a_q.push_back(n);
      wr_d_q.push_back(v);
    end
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    check_eq("busy_cycle1", busy, 1);
    done_cyc = 0; ndone = 0; arith_bad = 0;
    while (c < 200) begin
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy && nrn_arithm !== m) arith_bad++;
      if (poke && c == 10) begin start = 1'b1; mode = ~m; end
      if (poke && c == 11) start = 1'b0;
      if (abort_at != 0 && c == abort_at) rst_n = 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        check_eq("abort_busy", busy, 0);
        check_eq("abort_strobes", {vmem_rd_en, vmem_wr_en, nrn_load_en, nrn_input_valid, nrn_output_en, done}, 0);
        check_eq("abort_spike_vec", spike_vec, 0);
        rst_n = 1'b1;
        break;
      end
      if (done_cyc != 0 && c >= done_cyc + 5) break;
      @(negedge clk);
      c++;
    end
    if (abort_at != 0) begin
      rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
      for (int n = 1; n < NN; n++) exp_vmem[n] = saved[n];
      wr0 = wr_cnt;
      repeat (20) @(negedge clk);
      check_eq("abort_no_wr", wr_cnt - wr0, 0);
      return;
    end
    check_eq("done_cycle", done_cyc, NN * (NI + 5) + 1);
    check_eq("done_count", ndone, 1);
    check_eq("arithm_stable", arith_bad, 0);
    check_eq("spike_vec", spike_vec, es);
    check_eq("idle_after", busy, 0);
    check_eq("wr_q_drained", wr_a_q.size(), 0);
`ifdef IF_SCHED_SPIKE_CNT_EN
    check_eq("spike_cnt", spike_cnt, pop);
`endif
  endtask

  initial begin
    int c, d1, d2, nd;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; do_load = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 4; i++) act_mem[i] = 16'd1;
    for (int i = 0; i < 16; i++) w_mem[i] = 16'd1;
    vmem_init[3] = 16'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_strobes", {vmem_rd_en, vmem_wr_en, nrn_load_en, nrn_input_valid, nrn_output_en}, 0);
    check_eq("rst_spike_vec", spike_vec, 0);
    check_eq("rst_arithm", nrn_arithm, 0);
    check_eq("rst_busy_u1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Accumulate mode, unit activations and weights.
    load_mem(16'd0, 16'd100, 16'd130);
    run_ts(1'b1, 1'b0, 0);
    check_eq("vmem0_eq_4", vmem[0], 4);
    check_eq("vmem1_eq_104", vmem[1], 104);
    check_eq("vmem2_eq_7", vmem[2], 7);
    check_eq("spikes_110", spike_vec, 3'b110);

    // MAC mode with distinct weights per address.
    for (int i = 0; i < 4; i++) act_mem[i] = 16'(i + 1);
    for (int i = 0; i < 16; i++) w_mem[i] = 16'(i + 1);
    run_ts(1'b0, 1'b0, 0);
    run_ts(1'b1, 1'b1, 0);
    run_ts(1'b0, 1'b0, 13);
    run_ts(1'b1, 1'b0, 0);

    // One neuron, one input, start held high across DONE.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    c = 1; d1 = 0; d2 = 0; nd = 0;
    while (c <= 25) begin
      if (done1) begin
        nd++;
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (c == 8) check_eq("u1_idle_c8", busy1, 0);
      if (c == 9) begin
        check_eq("u1_refetch_c9", rd_en1, 1);
        start1 = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    check_eq("u1_done1_cycle", d1, 7);
    check_eq("u1_done2_cycle", d2, 15);
    check_eq("u1_done_count", nd, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
